// File: rtl/flit_credit_rx_buffer.sv
// Receive-side flit FIFO behind a valid-only pipeline: absorbs flits, presents them
// with valid/ready, and returns one upstream credit per freed entry plus DEPTH at reset.
module flit_credit_rx_buffer #(
  parameter int unsigned FLIT_DW = 512,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [FLIT_DW-1:0]           flit_data_in,
  input  logic                         flit_vld_in,
  output logic [FLIT_DW-1:0]           out_data,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic                         credit_ret,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PCW = CW + 1;

  logic [FLIT_DW-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      occ_q, occ_d;
  logic [CW-1:0]      pend_q, pend_d;
  logic               credit_q, credit_d;
  logic               ovf_q, ovf_d;

  logic               full, pop, push;
  logic [PCW-1:0]     pend_sum;

  // Next-state logic: FIFO bookkeeping, sticky overflow and credit engine
  always_comb begin
    full     = (occ_q == CW'(DEPTH));
    pop      = (occ_q != '0) & out_rdy;
    push     = flit_vld_in & (~full | pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    occ_d    = occ_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q | (flit_vld_in & full & ~pop);

    // Pending credits drain one per cycle; pops during the reset burst queue up here
    pend_sum = PCW'(pend_q) + PCW'(pop);
    credit_d = (pend_sum != '0);
    pend_d   = CW'(pend_sum - PCW'(credit_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pend_q   <= CW'(DEPTH);
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pend_q   <= pend_d;
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is intentionally unreset; head data is only meaningful while out_vld=1
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_data_in;
  end

  assign out_data     = mem_q[rd_ptr_q];
  assign out_vld      = (occ_q != '0);
  assign occupancy    = occ_q;
  assign credit_ret   = credit_q;
  assign overflow_err = ovf_q;

endmodule
